// File: rtl/axi_reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_reorder_buffer_if
//  Brief    : AR/R handshake bundle between read master, reorder buffer and
//             downstream read slave.
//  Revision : 1.0
// ============================================================================
interface axi_reorder_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   s_arid_i;
    logic                  s_arvalid_i;
    logic                  s_arready_o;
    logic [ID_WIDTH-1:0]   m_arid_o;
    logic                  m_arvalid_o;
    logic                  m_arready_i;
    logic [DATA_WIDTH-1:0] s_rdata_o;
    logic [ID_WIDTH-1:0]   s_rid_o;
    logic                  s_rvalid_o;
    logic                  s_rready_i;
    logic [DATA_WIDTH-1:0] m_rdata_i;
    logic [ID_WIDTH-1:0]   m_rid_i;
    logic                  m_rvalid_i;
    logic                  m_rready_o;

    // Reorder buffer side
    modport slave (
        input  s_arid_i, s_arvalid_i, m_arready_i, s_rready_i,
               m_rdata_i, m_rid_i, m_rvalid_i,
        output s_arready_o, m_arid_o, m_arvalid_o, s_rdata_o,
               s_rid_o, s_rvalid_o, m_rready_o
    );

    // Environment side (upstream master plus downstream slave)
    modport master (
        output s_arid_i, s_arvalid_i, m_arready_i, s_rready_i,
               m_rdata_i, m_rid_i, m_rvalid_i,
        input  s_arready_o, m_arid_o, m_arvalid_o, s_rdata_o,
               s_rid_o, s_rvalid_o, m_rready_o
    );
endinterface
`default_nettype wire

// File: rtl/axi_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_reorder_buffer
//  Brief    : Returns out-of-order single-beat read responses upstream in AR
//             issue order. Optional macro ROB_BYPASS_EN adds a same-cycle
//             forward path for a response that matches the current head.
//  Revision : 1.0
// ============================================================================
module axi_reorder_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,   // active-high synchronous reset
    axi_reorder_buffer_if.slave bus
);
    localparam int                  c_DEPTH     = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH:0]   c_DEPTH_CNT = {1'b1, {ID_WIDTH{1'b0}}};
    localparam logic [ID_WIDTH:0]   c_CNT_ONE   = 1;
    localparam logic [ID_WIDTH-1:0] c_PTR_ONE   = 1;

    logic [ID_WIDTH-1:0]   r_order [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [c_DEPTH];
    logic [ID_WIDTH-1:0]   r_wr_ptr;
    logic [ID_WIDTH-1:0]   r_rd_ptr;
    logic [ID_WIDTH:0]     r_count;
    logic [c_DEPTH-1:0]    r_pend;
    logic [c_DEPTH-1:0]    r_full;

    logic [ID_WIDTH-1:0]   w_head;
    logic                  w_not_empty;
    logic                  w_head_full;
    logic                  w_ar_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_store;
    logic                  w_byp_pop;
    logic                  w_s_rvalid;

    assign w_head      = r_order[r_rd_ptr];
    assign w_not_empty = (r_count != '0);
    assign w_head_full = w_not_empty && r_full[w_head];

    // An ID popped this cycle still has its full bit set, so it stays blocked
    assign w_ar_ok = !rst_n && (r_count < c_DEPTH_CNT)
                     && !r_pend[bus.s_arid_i] && !r_full[bus.s_arid_i];

    assign bus.m_arid_o    = bus.s_arid_i;
    assign bus.m_arvalid_o = bus.s_arvalid_i & w_ar_ok;
    assign bus.s_arready_o = bus.m_arready_i & w_ar_ok;
    assign w_push          = bus.s_arvalid_i & bus.m_arready_i & w_ar_ok;

    assign bus.m_rready_o  = !rst_n;

`ifdef ROB_BYPASS_EN
    logic w_byp_hit;

    assign w_byp_hit = !rst_n && w_not_empty && !r_full[w_head] && r_pend[w_head]
                       && bus.m_rvalid_i && (bus.m_rid_i == w_head);
    assign w_s_rvalid    = (!rst_n && w_head_full) || w_byp_hit;
    assign bus.s_rdata_o = w_byp_hit ? bus.m_rdata_i : r_data[w_head];
    assign w_byp_pop     = w_byp_hit & bus.s_rready_i;
`else
    assign w_s_rvalid    = !rst_n && w_head_full;
    assign bus.s_rdata_o = r_data[w_head];
    assign w_byp_pop     = 1'b0;
`endif

    assign bus.s_rvalid_o = w_s_rvalid;
    assign bus.s_rid_o    = w_head;
    assign w_pop          = w_s_rvalid & bus.s_rready_i;

    // Responses for IDs that are not pending fall through here and are dropped
    assign w_store = !rst_n && bus.m_rvalid_i && r_pend[bus.m_rid_i] && !w_byp_pop;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pend   <= '0;
            r_full   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
                r_pend[bus.s_arid_i]  <= 1'b1;
            end
            if (w_store) begin
                r_pend[bus.m_rid_i]   <= 1'b0;
                r_full[bus.m_rid_i]   <= 1'b1;
            end
            if (w_byp_pop) begin
                r_pend[w_head]        <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr              <= r_rd_ptr + c_PTR_ONE;
                r_full[w_head]        <= 1'b0;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage arrays carry no reset; validity lives in the pointers and flags
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_order[r_wr_ptr] <= bus.s_arid_i;
        end
        if (w_store) begin
            r_data[bus.m_rid_i] <= bus.m_rdata_i;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_reorder_buffer
//  Brief    : Directed scoreboard bench for axi_reorder_buffer.
//  Revision : 1.0
// ============================================================================
module tb_axi_reorder_buffer;
    localparam int DW = 8;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi_reorder_buffer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_reorder_buffer #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [IW+DW-1:0] exp_q [$];
    logic [IW+DW-1:0] mon_e;

    logic [IW-1:0] ord_a [16] = '{7, 2, 15, 0, 11, 4, 9, 13, 1, 6, 14, 3, 8, 12, 5, 10};
    logic [IW-1:0] ord_b [16] = '{3, 12, 0, 7, 10, 5, 15, 2, 9, 14, 1, 8, 4, 13, 6, 11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every upstream R handshake is compared against the scoreboard
    always @(negedge clk) begin
        if (!rst_n && bus.s_rvalid_o && bus.s_rready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_r: actual id %0d data 0x%0h, required no response",
                         bus.s_rid_o, bus.s_rdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("r_id",   32'(bus.s_rid_o),   32'(mon_e[DW +: IW]));
                check("r_data", 32'(bus.s_rdata_o), 32'(mon_e[DW-1:0]));
            end
        end
    end

    task automatic issue(input logic [IW-1:0] id, input logic [DW-1:0] d);
        int t = 0;
        bus.s_arid_i    = id;
        bus.s_arvalid_i = 1'b1;
        @(negedge clk);
        while (!bus.s_arready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!bus.s_arready_o) begin
            n_fail++;
            $display("FAIL ar_timeout: id %0d actual s_arready_o=0 required 1", id);
        end else begin
            exp_q.push_back({id, d});
        end
        @(posedge clk); #1;
        bus.s_arvalid_i = 1'b0;
    endtask

    task automatic respond(input logic [IW-1:0] id, input logic [DW-1:0] d);
        bus.m_rid_i    = id;
        bus.m_rdata_i  = d;
        bus.m_rvalid_i = 1'b1;
        @(posedge clk); #1;
        bus.m_rvalid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_arid_i    = '0;
        bus.s_arvalid_i = 1'b0;
        bus.m_arready_i = 1'b1;
        bus.s_rready_i  = 1'b1;
        bus.m_rdata_i   = '0;
        bus.m_rid_i     = '0;
        bus.m_rvalid_i  = 1'b0;

        // Reset behaviour and combinational AR forward
        bus.s_arid_i    = 4'd3;
        bus.s_arvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_arready",  32'(bus.s_arready_o), 32'd0);
        check("rst_m_arvalid",  32'(bus.m_arvalid_o), 32'd0);
        check("rst_m_rready",   32'(bus.m_rready_o),  32'd0);
        check("rst_s_rvalid",   32'(bus.s_rvalid_o),  32'd0);
        @(posedge clk); #1;
        rst_n           = 1'b0;
        bus.s_arvalid_i = 1'b0;
        @(negedge clk);
        check("post_rst_m_rready", 32'(bus.m_rready_o), 32'd1);
        check("post_rst_s_rvalid", 32'(bus.s_rvalid_o), 32'd0);
        @(posedge clk); #1;
        bus.s_arid_i    = 4'd3;
        bus.s_arvalid_i = 1'b1;
        @(negedge clk);
        check("ar_fwd_valid", 32'(bus.m_arvalid_o), 32'd1);
        check("ar_fwd_id",    32'(bus.m_arid_o),    32'd3);
        check("ar_ready",     32'(bus.s_arready_o), 32'd1);
        exp_q.push_back({4'd3, 8'd13});
        @(posedge clk); #1;
        bus.s_arvalid_i = 1'b0;
        respond(4'd3, 8'd13);
        drain();

        // In-order issue, reverse-order return
        for (int i = 0; i < 16; i++) issue(IW'(i), DW'(i + 10));
        for (int i = 15; i >= 0; i--) respond(IW'(i), DW'(i + 10));
        drain();

        // Shuffled issue, differently shuffled return
        for (int i = 0; i < 16; i++) issue(ord_a[i], DW'(ord_a[i]) + 8'h40);
        for (int i = 0; i < 16; i++) respond(ord_b[i], DW'(ord_b[i]) + 8'h40);
        drain();

        // Full buffer: 17th AR waits for the first pop, accepted one cycle later
        bus.s_rready_i = 1'b0;
        for (int i = 0; i < 16; i++) issue(IW'(i), DW'(i) + 8'h80);
        for (int i = 0; i < 16; i++) respond(IW'(i), DW'(i) + 8'h80);
        bus.s_arid_i    = 4'd0;
        bus.s_arvalid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_stall",  32'(bus.s_arready_o), 32'd0);
            check("full_rvalid", 32'(bus.s_rvalid_o),  32'd1);
        end
        @(posedge clk); #1;
        bus.s_rready_i = 1'b1;
        @(negedge clk);
        check("full_blocked_on_pop", 32'(bus.s_arready_o), 32'd0);
        @(posedge clk); #1;
        bus.s_rready_i = 1'b0;
        @(negedge clk);
        check("full_accept_after_pop", 32'(bus.s_arready_o), 32'd1);
        exp_q.push_back({4'd0, 8'h99});
        @(posedge clk); #1;
        bus.s_arvalid_i = 1'b0;
        bus.s_rready_i  = 1'b1;
        respond(4'd0, 8'h99);
        drain();

        // Duplicate ID stall and dropped unissued response
        issue(4'd5, 8'hA5);
        bus.s_arid_i    = 4'd5;
        bus.s_arvalid_i = 1'b1;
        @(negedge clk);
        check("dup_stall", 32'(bus.s_arready_o), 32'd0);
        check("dup_no_fwd", 32'(bus.m_arvalid_o), 32'd0);
        @(posedge clk); #1;
        respond(4'd9, 8'h77);
        @(negedge clk);
        check("drop_id9_rvalid", 32'(bus.s_rvalid_o),  32'd0);
        check("dup_stall_2",     32'(bus.s_arready_o), 32'd0);
        @(posedge clk); #1;
        respond(4'd5, 8'hA5);
        @(negedge clk);
        check("dup_blocked_on_pop", 32'(bus.s_arready_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dup_accept_after_pop", 32'(bus.s_arready_o), 32'd1);
        exp_q.push_back({4'd5, 8'hB5});
        @(posedge clk); #1;
        bus.s_arvalid_i = 1'b0;
        respond(4'd5, 8'hB5);
        drain();

        // Backpressure holds head stable
        bus.s_rready_i = 1'b0;
        for (int i = 1; i <= 4; i++) issue(IW'(i), DW'(i) + 8'hC0);
        for (int i = 4; i >= 1; i--) respond(IW'(i), DW'(i) + 8'hC0);
        repeat (4) begin
            @(negedge clk);
            check("hold_rvalid", 32'(bus.s_rvalid_o), 32'd1);
            check("hold_rid",    32'(bus.s_rid_o),    32'd1);
            check("hold_rdata",  32'(bus.s_rdata_o),  32'hC1);
        end

        // Reset mid-operation discards buffered entries
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_rvalid", 32'(bus.s_rvalid_o), 32'd0);
        @(posedge clk); #1;
        rst_n          = 1'b0;
        bus.s_rready_i = 1'b1;
        @(negedge clk);
        check("after_midrst_rvalid", 32'(bus.s_rvalid_o), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) issue(IW'(i), DW'(i) + 8'hD0);
        for (int i = 0; i < 16; i++) respond(ord_b[i], DW'(ord_b[i]) + 8'hD0);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
